// File: rtl/npu_pkg.sv
// Shared state encoding and default geometry for the convolution window sequencer.
package npu_pkg;

  localparam int KERNEL_H = 3;
  localparam int DEF_IN_H = 16;
  localparam int DEF_IN_W = 15;
  localparam int DEF_K_W  = 3;

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    LOAD,
    WAIT,
    CAL,
    MINUS,
    EMIT,
    DONE
  } conv_state_e;

endpackage

// File: rtl/npu_win_pos_cnt.sv
// Output-window position (row/column) and per-window column load-beat counters.
module npu_win_pos_cnt
  import npu_pkg::*;
#(
  parameter int  IN_H  = DEF_IN_H,
  parameter int  IN_W  = DEF_IN_W,
  parameter int  K_W   = DEF_K_W,
  localparam int OUT_H = IN_H - KERNEL_H + 1,
  localparam int OUT_W = IN_W - K_W + 1,
  localparam int RW    = $clog2(IN_H),
  localparam int CW    = $clog2(IN_W)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pos_clr_i,
  input  logic          adv_i,
  input  logic          beat_clr_i,
  input  logic          beat_inc_i,
  output logic [RW-1:0] row_o,
  output logic [CW-1:0] col_o,
  output logic [CW-1:0] beat_o,
  output logic          col_wrap_o,
  output logic          last_pos_o,
  output logic          last_beat_o
);

  logic [RW-1:0] row_q, row_d;
  logic [CW-1:0] col_q, col_d;
  logic [CW-1:0] beat_q, beat_d;

  assign row_o      = row_q;
  assign col_o      = col_q;
  assign beat_o     = beat_q;
  assign col_wrap_o = (col_q == CW'(OUT_W - 1));
  assign last_pos_o = col_wrap_o && (row_q == RW'(OUT_H - 1));

  // Column 0 reloads the whole kernel width; later columns slide in one new column.
  assign last_beat_o = (col_q != '0) || (beat_q == CW'(K_W - 1));

  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (pos_clr_i) begin
      row_d = '0;
      col_d = '0;
    end else if (adv_i) begin
      if (last_pos_o) begin
        row_d = '0;
        col_d = '0;
      end else if (col_wrap_o) begin
        row_d = row_q + 1'b1;
        col_d = '0;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_comb begin
    beat_d = beat_q;
    if (beat_clr_i) begin
      beat_d = '0;
    end else if (beat_inc_i) begin
      beat_d = beat_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row_q  <= '0;
      col_q  <= '0;
      beat_q <= '0;
    end else begin
      row_q  <= row_d;
      col_q  <= col_d;
      beat_q <= beat_d;
    end
  end

endmodule

// File: rtl/npu_conv_seq.sv
// Full-layer sweep sequencer for a 3-row PE convolution array: column fetch,
// PE accumulate/negate phases and result handshake per output position.
module npu_conv_seq
  import npu_pkg::*;
#(
  parameter int  IN_H = DEF_IN_H,
  parameter int  IN_W = DEF_IN_W,
  parameter int  K_W  = DEF_K_W,
  localparam int RW   = $clog2(IN_H),
  localparam int CW   = $clog2(IN_W)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  output logic          busy,
  output logic          done,
  output logic          col_rd_en,
  output logic [RW-1:0] col_rd_row,
  output logic [CW-1:0] col_rd_col,
  output logic          img_load_en,
  output logic          img_clr,
  output logic          pe_clr,
  output logic          pe_ready,
  output logic          sel_neg,
  output logic          w_shift,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [RW-1:0] out_row,
  output logic [CW-1:0] out_col
);

  conv_state_e   state_q, state_d;
  logic          img_load_en_q;
  logic [RW-1:0] pos_row;
  logic [CW-1:0] pos_col;
  logic [CW-1:0] beat;
  logic          col_wrap;
  logic          last_pos;
  logic          last_beat;
  logic          pos_clr;
  logic          pos_adv;

  assign pos_clr = abort || ((state_q == IDLE) && start);
  assign pos_adv = (state_q == EMIT) && out_ready && !abort;

  npu_win_pos_cnt #(
    .IN_H (IN_H),
    .IN_W (IN_W),
    .K_W  (K_W)
  ) u_pos_cnt (
    .clk         (clk),
    .rst         (rst),
    .pos_clr_i   (pos_clr),
    .adv_i       (pos_adv),
    .beat_clr_i  (state_q == CLR),
    .beat_inc_i  (state_q == LOAD),
    .row_o       (pos_row),
    .col_o       (pos_col),
    .beat_o      (beat),
    .col_wrap_o  (col_wrap),
    .last_pos_o  (last_pos),
    .last_beat_o (last_beat)
  );

  assign out_row     = pos_row;
  assign out_col     = pos_col;
  assign img_load_en = img_load_en_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      img_load_en_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      // The image buffer answers one cycle after the read; a dropped sweep must not load.
      img_load_en_q <= col_rd_en && !abort;
    end
  end

  always_comb begin
    state_d    = state_q;
    busy       = (state_q != IDLE);
    done       = 1'b0;
    pe_clr     = 1'b0;
    img_clr    = 1'b0;
    col_rd_en  = 1'b0;
    col_rd_row = '0;
    col_rd_col = '0;
    pe_ready   = 1'b0;
    sel_neg    = 1'b0;
    w_shift    = 1'b0;
    out_valid  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) state_d = CLR;
      end
      CLR: begin
        pe_clr  = 1'b1;
        img_clr = (pos_col == '0);
        state_d = LOAD;
      end
      LOAD: begin
        col_rd_en  = 1'b1;
        col_rd_row = pos_row;
        col_rd_col = (pos_col == '0) ? beat : pos_col + CW'(K_W - 1);
        if (last_beat) state_d = WAIT;
      end
      WAIT: begin
        state_d = CAL;
      end
      CAL: begin
        pe_ready = 1'b1;
        state_d  = MINUS;
      end
      MINUS: begin
        pe_ready = 1'b1;
        sel_neg  = 1'b1;
        w_shift  = 1'b1;
        state_d  = EMIT;
      end
      EMIT: begin
        out_valid = 1'b1;
        if (out_ready) state_d = last_pos ? DONE : CLR;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Abort outranks every transition, including a simultaneous start in IDLE.
    if (abort) state_d = IDLE;
  end

  logic unused_col_wrap;
  assign unused_col_wrap = col_wrap;

endmodule

// File: tb/tb_npu_conv_seq.sv
// Directed self-checking bench for npu_conv_seq with a coordinate scoreboard.
module tb_npu_conv_seq;

  localparam int OUT_H_TB = 14;
  localparam int OUT_W_TB = 13;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       abort;
  logic       out_ready;
  logic       busy;
  logic       done;
  logic       col_rd_en;
  logic [3:0] col_rd_row;
  logic [3:0] col_rd_col;
  logic       img_load_en;
  logic       img_clr;
  logic       pe_clr;
  logic       pe_ready;
  logic       sel_neg;
  logic       w_shift;
  logic       out_valid;
  logic [3:0] out_row;
  logic [3:0] out_col;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;
  int t0         = 0;
  int doneCount  = 0;
  int doneCycle  = -1;
  int hsCount    = 0;
  int found;
  logic [7:0] sbq[$];

  // Strobe vector {busy,done,out_valid,w_shift,sel_neg,pe_ready,img_load_en,col_rd_en,img_clr,pe_clr}
  // for cycles 1..11 of a sweep: the column-0 window followed by the column-1 window.
  logic [9:0] firstWin [0:10] = '{
    10'b1000000011,
    10'b1000000100,
    10'b1000001100,
    10'b1000001100,
    10'b1000001000,
    10'b1000010000,
    10'b1001110000,
    10'b1010000000,
    10'b1000000001,
    10'b1000000100,
    10'b1000001000
  };

  npu_conv_seq dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .abort       (abort),
    .busy        (busy),
    .done        (done),
    .col_rd_en   (col_rd_en),
    .col_rd_row  (col_rd_row),
    .col_rd_col  (col_rd_col),
    .img_load_en (img_load_en),
    .img_clr     (img_clr),
    .pe_clr      (pe_clr),
    .pe_ready    (pe_ready),
    .sel_neg     (sel_neg),
    .w_shift     (w_shift),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_row     (out_row),
    .out_col     (out_col)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic a, input logic r);
    start     = s;
    abort     = a;
    out_ready = r;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [9:0] strobes();
    return {busy, done, out_valid, w_shift, sel_neg, pe_ready,
            img_load_en, col_rd_en, img_clr, pe_clr};
  endfunction

  // Loads the expected row-major coordinate stream, then pulses start so that
  // the following edge is edge 0 and the bench sits in cycle 1 on return.
  task automatic startSweep();
    sbq.delete();
    for (int r = 0; r < OUT_H_TB; r++)
      for (int c = 0; c < OUT_W_TB; c++)
        sbq.push_back({4'(r), 4'(c)});
    doneCount = 0;
    doneCycle = -1;
    hsCount   = 0;
    applyStimulus(1'b1, 1'b0, 1'b1);
    tick();
    t0 = cyc - 1;
    applyStimulus(1'b0, 1'b0, 1'b1);
  endtask

  // Scoreboard consumer: every accepted result must match the next expected coordinate.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (out_valid && out_ready) begin
        hsCount++;
        if (sbq.size() == 0) begin
          compared++;
          mismatched++;
          $error("[TB] FAIL sb_underflow: observed=%0h expected=none", {out_row, out_col});
        end else begin
          checkOutput("handshake_pos", {out_row, out_col}, sbq.pop_front());
        end
      end
      if (done) begin
        doneCount++;
        doneCycle = cyc - t0;
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0);
    tick();
    tick();
    tick();
    checkOutput("reset_strobes", strobes(), 10'b0);
    checkOutput("reset_coords", {out_row, out_col, col_rd_row, col_rd_col}, 16'h0);
    rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b1);
    tick();
    checkOutput("idle_after_reset", {strobes(), out_row, out_col}, 18'h0);

    // Full sweep with out_ready held high, plus a stray start while busy.
    startSweep();
    for (int k = 1; k <= 1122; k++) begin
      if (k > 1) tick();
      if (k == 50) applyStimulus(1'b1, 1'b0, 1'b1);
      else if (k == 51) applyStimulus(1'b0, 1'b0, 1'b1);
      if (k <= 11) begin
        checkOutput($sformatf("win0_strobes_c%0d", k), strobes(), firstWin[k-1]);
        if ((k >= 2 && k <= 4) || k == 10)
          checkOutput($sformatf("win0_rdaddr_c%0d", k), {col_rd_row, col_rd_col},
                      8'(k == 10 ? 3 : k - 2));
      end
      if (k >= 81 && k <= 84) begin
        checkOutput($sformatf("wrap_strobes_c%0d", k), strobes(), firstWin[k-81]);
        if (k >= 82)
          checkOutput($sformatf("wrap_rdaddr_c%0d", k), {col_rd_row, col_rd_col},
                      8'h10 + 8'(k - 82));
      end
      if (k == 1120)
        checkOutput("last_emit", {strobes(), out_row, out_col}, {10'b1010000000, 4'd13, 4'd12});
      if (k == 1121) checkOutput("done_cycle_strobes", strobes(), 10'b1100000000);
      if (k == 1122) checkOutput("idle_after_done", strobes(), 10'b0);
    end
    checkOutput("sweep_handshakes", hsCount, 182);
    checkOutput("sweep_done_count", doneCount, 1);
    checkOutput("sweep_done_cycle", doneCycle, 1121);
    checkOutput("sweep_sb_empty", sbq.size(), 0);

    // Back-pressure at (0,4), then abort during the LOAD of (3,7).
    startSweep();
    found = 0;
    for (int n = 0; n < 200 && found == 0; n++) begin
      if (out_valid && out_row == 4'd0 && out_col == 4'd4) found = 1;
      else tick();
    end
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("hold_found", found, 1);
    checkOutput("hold_arrival_cycle", cyc - t0, 32);
    for (int h = 1; h <= 5; h++) begin
      tick();
      checkOutput($sformatf("hold_stable_%0d", h),
                  {out_valid, pe_ready, col_rd_en, out_row, out_col}, {3'b100, 4'd0, 4'd4});
    end
    applyStimulus(1'b0, 1'b0, 1'b1);
    tick();
    checkOutput("resume_pos", {strobes(), out_row, out_col}, {10'b1000000001, 4'd0, 4'd5});

    found = 0;
    for (int n = 0; n < 2000 && found == 0; n++) begin
      if (col_rd_en && out_row == 4'd3 && out_col == 4'd7) found = 1;
      else tick();
    end
    checkOutput("abort_found", found, 1);
    checkOutput("abort_load_cycle", cyc - t0, 291);
    applyStimulus(1'b0, 1'b1, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("abort_idle", {strobes(), out_row, out_col}, 18'h0);
    checkOutput("abort_no_done", doneCount, 0);
    tick();
    checkOutput("abort_idle_hold", strobes(), 10'b0);
    sbq.delete();

    // Restart after abort must begin again at (0,0) and complete normally.
    startSweep();
    found = 0;
    for (int n = 0; n < 1300 && found == 0; n++) begin
      if (!busy) found = 1;
      else tick();
    end
    checkOutput("restart_finished", found, 1);
    checkOutput("restart_handshakes", hsCount, 182);
    checkOutput("restart_done_cycle", doneCycle, 1121);
    checkOutput("restart_sb_empty", sbq.size(), 0);

    // Simultaneous start and abort in IDLE: abort wins.
    applyStimulus(1'b1, 1'b1, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("start_abort_idle", strobes(), 10'b0);
    tick();
    checkOutput("start_abort_idle_hold", strobes(), 10'b0);

    // Reset mid-sweep overrides a concurrent start.
    startSweep();
    tick();
    rst = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b1);
    tick();
    checkOutput("midreset_outputs", {strobes(), out_row, out_col, col_rd_row, col_rd_col}, 26'h0);
    rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b1);
    tick();
    checkOutput("midreset_idle", strobes(), 10'b0);
    sbq.delete();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
